// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, PC step and alignment helpers.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_INC     = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [1:0] pc_lsb);
    return (pc_lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Instruction buffer: synchronous FIFO with a registered head output.
// Flush wins over push and pop in the same cycle.
module inst_fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = head_q;

  // Next head is the entry at the new read pointer, bypassing a same-cycle write to that slot.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (do_push) wr_d = wr_q + AW'(1);
      cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
      head_d = (do_push && (wr_q == rd_d)) ? push_data_i : mem_q[rd_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[AW'(i)] <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: sequential PC generation, credit-limited memory requests,
// buffered in-order delivery to the core, and redirect handling with stale-response drop.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h8000_0000),
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            fetch_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;
  logic [2*XLEN-1:0] fifo_head;
  logic              fifo_push, fifo_pop;
  logic              credit_ok, req_fire, resp_keep;

  // Requests are limited so buffered plus in-flight words never exceed the buffer size.
  assign credit_ok      = (SW'(fifo_count) + SW'(outst_q)) < SW'(FIFO_DEPTH);
  assign imem_req_valid = (state_q == ST_RUN) && credit_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_keep = imem_resp_valid && (drop_q == '0) && !redirect_valid;
  assign fifo_push = resp_keep && (!fifo_full || fifo_pop);
  assign fifo_pop  = out_valid && out_ready;

  assign out_valid = !fifo_empty && (state_q != ST_ERR);
  assign fetch_err = (state_q == ST_ERR);
  assign out_pc    = fifo_head[2*XLEN-1:XLEN];
  assign out_inst  = fifo_head[XLEN-1:0];

  inst_fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i ({resp_pc_q, imem_resp_data}),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Next-state: a redirect overrides normal PC advance and turns every in-flight response stale.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
    drop_d     = drop_q;

    if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (req_fire)  fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
    if (resp_keep) resp_pc_d  = resp_pc_q + XLEN'(PC_INC);

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      default: state_d = state_q;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_d     = outst_q - CW'(imem_resp_valid);
      state_d    = is_aligned(redirect_pc[1:0]) ? ST_RUN : ST_ERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage directly upstream of the core's decode/execute datapath.
- Generates sequential PCs from a reset vector and issues in-order requests to instruction memory over a valid/ready request channel.
- Buffers returned instructions in a small FIFO and presents them, paired with their PC, to the core via out_valid/out_ready.
- Handles redirects (jump/branch) by flushing the buffer and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h80000000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2; also the maximum outstanding requests.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  fetch address.
- imem_resp_valid  in  1  response valid; responses return in request order, >= 1 cycle after acceptance.
- imem_resp_data  in  XLEN  instruction word.
- redirect_valid  in  1  single-cycle redirect strobe from the core.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  buffered instruction available.
- out_ready  in  1  core consumes the head entry.
- out_inst  out  XLEN  head instruction.
- out_pc  out  XLEN  PC of the head instruction.
- fetch_err  out  1  misaligned redirect received; fetch halted.

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; state=BOOT.
  - Outputs: imem_req_valid=0, out_valid=0, fetch_err=0, out_inst=0, out_pc=0.
- State BOOT:
  - No requests.
  - First rising edge after rst deasserts -> RUN.
- State RUN:
  - imem_req_valid = (fifo_count + outstanding < FIFO_DEPTH) && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - On a req handshake: fetch_pc += 4 (mod 2^XLEN, silent wrap); outstanding += 1.
- Response with drop_cnt > 0:
  - Response discarded; drop_cnt -= 1; outstanding -= 1.
- Response with drop_cnt == 0:
  - Word pushed with its PC (tracked by a resp_pc register advancing by 4 per accepted response); outstanding -= 1.
  - The credit rule guarantees the push never overflows the FIFO.
- Output:
  - out_valid = FIFO non-empty and state != ERR.
  - Head pops on out_valid && out_ready.
  - FIFO output is registered: a response at cycle t is visible at t+1 at the earliest.
- Simultaneous push and pop: both take effect; count unchanged.
- Redirect (redirect_valid=1 in cycle t), aligned target (redirect_pc[1:0]==0):
  - FIFO cleared, including any push or pop that cycle.
  - drop_cnt = outstanding minus any response arriving in cycle t; that response is also dropped.
  - fetch_pc = resp_pc = redirect_pc.
  - No request is issued in cycle t; the memory tolerates request withdrawal only in a redirect cycle.
  - First request to redirect_pc at t+1.
- Redirect with misaligned target:
  - Flush as above; state -> ERR; fetch_err=1; no requests.
  - In-flight responses are still counted and dropped.
- State ERR:
  - Exits only on an aligned redirect: -> RUN, fetch_err=0, same timing as a normal redirect.
- Redirect in BOOT:
  - Honoured: fetch_pc=redirect_pc, -> RUN.
- Counter widths: $clog2(FIFO_DEPTH)+1 for fifo_count, outstanding and drop_cnt.
- Minimum latency: redirect at t -> request at t+1 -> response at t+2 -> out_valid at t+3.
- Reset asserted mid-operation: immediate return to reset values.
  - Responses to pre-reset requests are the memory's responsibility (the memory is reset alongside).

Decomposition:
- Shared header fetch_defs.vh: state encodings BOOT/RUN/ERR, PC increment constant 4, alignment mask.
- Sub-module inst_fetch_fifo:
  - Parameterised synchronous FIFO (width 2*XLEN, depth FIFO_DEPTH) with push, pop, flush, count, empty and full.
  - Registered head output; flush has priority over push and pop.

Test Plan:
- Reset release, memory always ready, 1-cycle response -> requests at 0x80000000, 0x80000004, 0x80000008...; out_pc follows in order with matching out_inst.
- out_ready=0, memory ready -> exactly FIFO_DEPTH (4) requests issued, then imem_req_valid=0 until a pop.
- Response latency 3 cycles, redirect to 0x80000100 while 2 requests are outstanding -> both stale responses dropped; first out_pc=0x80000100.
- Redirect coinciding with a response and with out_ready=1 -> FIFO empty next cycle; stale word never appears; next request addr equals the redirect target.
- Redirect to 0x80000102 -> fetch_err=1, no requests; then redirect to 0x80000200 -> fetch_err=0, fetch resumes at 0x80000200.
- Redirect to 0xFFFFFFF8 with streaming fetch -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
